// File: rtl/aes128_encrypt_iter_pkg.sv
// rtl/aes128_encrypt_iter_pkg.sv - shared AES GF(2^8) helpers, forward S-box, rcon and state byte indexing
package aes128_encrypt_iter_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  // MSB position of state byte (row, col); byte 0 sits at [127:120], column-major
  function automatic logic [6:0] msb(input int col, input int row);
    return 7'(127 - 8 * (4 * col + row));
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;  4'd4: return 8'h08;
      4'd5: return 8'h10;  4'd6: return 8'h20;  4'd7: return 8'h40;  4'd8: return 8'h80;
      4'd9: return 8'h1b;  4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/aes128_encrypt_iter_encryption_round.sv
// rtl/aes128_encrypt_iter_encryption_round.sv - combinational AES forward round (SubBytes, ShiftRows, MixColumns, AddRoundKey)
module encryption_round
  import aes128_encrypt_iter_pkg::*;
(
  input  logic [127:0] instate,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] outstate
);

  logic [127:0] sr;
  logic [127:0] mc;
  logic [7:0]   a [4];

  always_comb begin
    sr = '0;
    mc = '0;
    for (int i = 0; i < 4; i++) a[i] = 8'h00;
    // Row r of output column c comes from input column (c+r) mod 4
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[msb(c, r) -: 8] = sbox(instate[msb((c + r) % 4, r) -: 8]);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = sr[msb(c, r) -: 8];
      mc[msb(c, 0) -: 8] = xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3];
      mc[msb(c, 1) -: 8] = a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3];
      mc[msb(c, 2) -: 8] = a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3];
      mc[msb(c, 3) -: 8] = xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3]);
    end
  end

  assign outstate = (last_round ? sr : mc) ^ round_key;

endmodule

// File: rtl/aes128_encrypt_iter.sv
// rtl/aes128_encrypt_iter.sv - iterative AES-128 encryption, one round per clock, on-the-fly key expansion
module aes128_encrypt_iter
  import aes128_encrypt_iter_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext
);

  if (NR != 10) begin : g_nr_check
    $error("aes128_encrypt_iter supports only NR=10");
  end

  state_t       cur, nxt;
  logic [127:0] state_reg, rk_reg, rk_next, round_out;
  logic [3:0]   rnd;
  logic         last_round;
  logic [31:0]  w3_rot, temp, k0, k1, k2, k3;

  assign last_round = (rnd == 4'(NR));
  assign in_ready   = (cur == ST_IDLE);
  assign out_valid  = (cur == ST_DONE);

  // Next round key derived from the current one; rcon indexed by the round being computed
  assign w3_rot  = {rk_reg[23:0], rk_reg[31:24]};
  assign temp    = {sbox(w3_rot[31:24]) ^ rcon(rnd), sbox(w3_rot[23:16]),
                    sbox(w3_rot[15:8]), sbox(w3_rot[7:0])};
  assign k0      = rk_reg[127:96] ^ temp;
  assign k1      = rk_reg[95:64] ^ k0;
  assign k2      = rk_reg[63:32] ^ k1;
  assign k3      = rk_reg[31:0] ^ k2;
  assign rk_next = {k0, k1, k2, k3};

  encryption_round u_round (
    .instate   (state_reg),
    .round_key (rk_next),
    .last_round(last_round),
    .outstate  (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= ST_IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      ST_IDLE: if (in_valid) nxt = ST_RUN;
      ST_RUN:  if (last_round) nxt = ST_DONE;
      ST_DONE: if (out_ready) nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= '0;
      rk_reg     <= '0;
      rnd        <= '0;
      ciphertext <= '0;
    end else if (cur == ST_IDLE && in_valid) begin
      state_reg <= plaintext ^ key;
      rk_reg    <= key;
      rnd       <= 4'd1;
    end else if (cur == ST_RUN) begin
      state_reg <= round_out;
      rk_reg    <= rk_next;
      rnd       <= rnd + 4'd1;
      if (last_round) ciphertext <= round_out;
    end
  end

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// tb/tb_aes128_encrypt_iter.sv - directed FIPS-197 checks for aes128_encrypt_iter
module tb_aes128_encrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] plaintext = '0;
  logic [127:0] key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] ciphertext;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RK1_C = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

  int errors = 0;
  int checks = 0;

  aes128_encrypt_iter #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .plaintext (plaintext),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ciphertext(ciphertext)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    int rises;
    int rise_cyc [2];
    logic [127:0] rise_ct [2];
    logic prev_ov;

    // Reset state
    #12;
    check("reset_in_ready", 128'(in_ready), 128'd1);
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_ciphertext", ciphertext, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // App. B: latency and in_ready profile
    plaintext = PT_B; key = KEY_B; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("b_in_ready_after_e0", 128'(in_ready), 128'd0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 9) check("b_out_valid_e9", 128'(out_valid), 128'd0);
    end
    check("b_out_valid_e10", 128'(out_valid), 128'd1);
    check("b_ciphertext", ciphertext, CT_B);
    check("b_in_ready_done", 128'(in_ready), 128'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("b_out_valid_drop", 128'(out_valid), 128'd0);
    check("b_in_ready_back", 128'(in_ready), 128'd1);

    // App. C.1 with inputs scrambled every cycle during RUN
    plaintext = PT_C; key = KEY_C; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      key       = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (i == 1) check("c_round1_key", dut.rk_reg, RK1_C);
    end
    check("c_out_valid", 128'(out_valid), 128'd1);
    check("c_ciphertext", ciphertext, CT_C);

    // Backpressure: 20 cycles held, new offer must be ignored
    plaintext = PT_B; key = KEY_B; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_out_valid", 128'(out_valid), 128'd1);
      check("bp_ciphertext", ciphertext, CT_C);
      check("bp_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_drop_out_valid", 128'(out_valid), 128'd0);
    check("bp_drop_in_ready", 128'(in_ready), 128'd1);
    check("bp_ct_retained", ciphertext, CT_C);
    tick();
    in_valid = 1'b0;
    check("bp_accept_next", 128'(in_ready), 128'd0);
    repeat (10) tick();
    check("bp_next_out_valid", 128'(out_valid), 128'd1);
    check("bp_next_ciphertext", ciphertext, CT_B);
    out_ready = 1'b1;
    tick();

    // Back-to-back: B then C.1 with in_valid and out_ready tied high
    plaintext = PT_B; key = KEY_B; in_valid = 1'b1;
    tick();
    plaintext = PT_C; key = KEY_C;
    rises = 0;
    prev_ov = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (out_valid && !prev_ov && rises < 2) begin
        rise_cyc[rises] = c;
        rise_ct[rises]  = ciphertext;
        rises++;
      end
      if (rises >= 1 && !in_ready && !out_valid) in_valid = 1'b0;
      prev_ov = out_valid;
    end
    in_valid = 1'b0;
    check("b2b_rise_count", 128'(rises), 128'd2);
    if (rises == 2) begin
      check("b2b_first_latency", 128'(rise_cyc[0]), 128'd10);
      check("b2b_spacing", 128'(rise_cyc[1] - rise_cyc[0]), 128'd12);
      check("b2b_ct_b", rise_ct[0], CT_B);
      check("b2b_ct_c", rise_ct[1], CT_C);
    end
    out_ready = 1'b0;
    tick();

    // Reset mid-run, then a clean App. B run
    plaintext = PT_C; key = KEY_C; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_ciphertext", ciphertext, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    plaintext = PT_B; key = KEY_B; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    check("post_rst_out_valid", 128'(out_valid), 128'd1);
    check("post_rst_ciphertext", ciphertext, CT_B);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_rst_drop", 128'(out_valid), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
